// File: rtl/router_rd_port_bank.sv
// Read-side port bank for the router output stage: NCH FIFO channels, each with its own
// read handshake, header tagging and a stall watchdog that flushes a stuck channel.
module router_rd_port_bank #(
  parameter int unsigned NCH     = 3,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               lfd_in,
  input  logic [NCH-1:0]     write_enb,
  output logic [NCH-1:0]     fifo_full,
  input  logic [NCH-1:0]     read_enb,
  output logic [NCH-1:0]     valid_out,
  output logic [NCH*WIDTH-1:0] data_out,
  output logic [NCH-1:0]     hdr_out,
  output logic [NCH-1:0]     soft_reset
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StWait, StFlush} wd_state_e;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH:0]   r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_data;
    logic             r_hdr;
    wd_state_e        r_state;
    wd_state_e        w_state_nxt;
    logic [TW-1:0]    r_wd_cnt;
    logic [TW-1:0]    w_wd_cnt_nxt;

    logic w_full;
    logic w_valid;
    logic w_flush;
    logic w_wr;
    logic w_rd;
    logic w_stall;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_valid = (r_count != '0);
    assign w_flush = (r_state == StFlush);
    // The flush cycle owns the channel: both the write and any read are suppressed.
    assign w_wr    = write_enb[i] & ~w_full & ~w_flush;
    assign w_rd    = read_enb[i] & w_valid & ~w_flush;
    assign w_stall = w_valid & ~read_enb[i];

    always_ff @(posedge clk) begin
      if (!resetn && w_wr) begin
        r_mem[r_wr_ptr] <= {lfd_in, data_in};
      end
    end

    always_ff @(posedge clk) begin
      if (resetn) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_data   <= '0;
        r_hdr    <= 1'b0;
      end else if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_rd) begin
          r_data   <= r_mem[r_rd_ptr][WIDTH-1:0];
          r_hdr    <= r_mem[r_rd_ptr][WIDTH];
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        if (w_wr && !w_rd) begin
          r_count <= r_count + CW'(1);
        end else if (!w_wr && w_rd) begin
          r_count <= r_count - CW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (resetn) begin
        r_state  <= StIdle;
        r_wd_cnt <= '0;
      end else begin
        r_state  <= w_state_nxt;
        r_wd_cnt <= w_wd_cnt_nxt;
      end
    end

    // r_wd_cnt holds the number of consecutive stalled edges already seen, so the edge
    // that completes TIMEOUT of them moves straight to StFlush.
    always_comb begin
      w_state_nxt  = r_state;
      w_wd_cnt_nxt = r_wd_cnt;
      unique case (r_state)
        StIdle: begin
          w_wd_cnt_nxt = '0;
          if (w_stall) begin
            if (TIMEOUT == 1) begin
              w_state_nxt = StFlush;
            end else begin
              w_state_nxt  = StWait;
              w_wd_cnt_nxt = TW'(1);
            end
          end
        end
        StWait: begin
          if (!w_stall) begin
            w_state_nxt  = StIdle;
            w_wd_cnt_nxt = '0;
          end else if (r_wd_cnt == TW'(TIMEOUT - 1)) begin
            w_state_nxt  = StFlush;
            w_wd_cnt_nxt = '0;
          end else begin
            w_wd_cnt_nxt = r_wd_cnt + TW'(1);
          end
        end
        StFlush: begin
          w_state_nxt  = StIdle;
          w_wd_cnt_nxt = '0;
        end
        default: begin
          w_state_nxt  = StIdle;
          w_wd_cnt_nxt = '0;
        end
      endcase
    end

    assign fifo_full[i]               = w_full;
    assign valid_out[i]               = w_valid;
    assign data_out[i*WIDTH +: WIDTH] = r_data;
    assign hdr_out[i]                 = r_hdr;
    assign soft_reset[i]              = w_flush;
  end

endmodule

// File: tb/tb_router_rd_port_bank.sv
// Scoreboard bench for router_rd_port_bank: per-channel expected-word queues filled on
// write, popped and compared when the read data appears.
module tb_router_rd_port_bank;

  localparam int unsigned NCH   = 3;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b1;
  logic [WIDTH-1:0]     data_in = '0;
  logic                 lfd_in = 1'b0;
  logic [NCH-1:0]       write_enb = '0;
  logic [NCH-1:0]       fifo_full;
  logic [NCH-1:0]       read_enb = '0;
  logic [NCH-1:0]       valid_out;
  logic [NCH*WIDTH-1:0] data_out;
  logic [NCH-1:0]       hdr_out;
  logic [NCH-1:0]       soft_reset;

  router_rd_port_bank #(
    .NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(30)
  ) dut (
    .clk(clk), .resetn(resetn), .data_in(data_in), .lfd_in(lfd_in),
    .write_enb(write_enb), .fifo_full(fifo_full), .read_enb(read_enb),
    .valid_out(valid_out), .data_out(data_out), .hdr_out(hdr_out),
    .soft_reset(soft_reset)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int m_cnt [NCH];
  logic [WIDTH:0] sb0 [$];
  logic [WIDTH:0] sb1 [$];
  logic [WIDTH:0] sb2 [$];
  logic [WIDTH:0] last_rd [NCH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear(input int ch);
    m_cnt[ch] = 0;
    case (ch)
      0: sb0.delete();
      1: sb1.delete();
      default: sb2.delete();
    endcase
  endtask

  task automatic sb_push(input int ch, input logic [WIDTH:0] v);
    if (m_cnt[ch] < DEPTH) begin
      m_cnt[ch]++;
      case (ch)
        0: sb0.push_back(v);
        1: sb1.push_back(v);
        default: sb2.push_back(v);
      endcase
    end
  endtask

  task automatic sb_pop(input int ch, output logic [WIDTH:0] v, output bit ok);
    ok = 1'b1;
    v  = '0;
    case (ch)
      0: if (sb0.size() == 0) ok = 1'b0; else v = sb0.pop_front();
      1: if (sb1.size() == 0) ok = 1'b0; else v = sb1.pop_front();
      default: if (sb2.size() == 0) ok = 1'b0; else v = sb2.pop_front();
    endcase
    if (ok) m_cnt[ch]--;
  endtask

  task automatic wr(input int ch, input logic lfd, input logic [WIDTH-1:0] d);
    write_enb     = '0;
    write_enb[ch] = 1'b1;
    data_in       = d;
    lfd_in        = lfd;
    sb_push(ch, {lfd, d});
    tick();
    write_enb = '0;
    lfd_in    = 1'b0;
  endtask

  // Read request on one edge; the word is compared just after that edge.
  task automatic rd_check(input int ch, input string name);
    logic [WIDTH:0] exp_v;
    logic [WIDTH:0] got;
    bit ok;
    read_enb[ch] = 1'b1;
    tick();
    read_enb = '0;
    sb_pop(ch, exp_v, ok);
    got = {hdr_out[ch], data_out[ch*WIDTH +: WIDTH]};
    n_checks++;
    if (!ok) begin
      $display("FAIL %s ch%0d: scoreboard empty, got %h", name, ch, got);
    end else if (got !== exp_v) begin
      $display("FAIL %s ch%0d: got {hdr,data}=%h required %h", name, ch, got, exp_v);
    end else begin
      n_pass++;
    end
    if (ok) last_rd[ch] = exp_v;
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    tick();
    tick();
    resetn = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      model_clear(c);
      last_rd[c] = '0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (valid_out !== 3'b000) $display("FAIL reset_valid: got %b required 000", valid_out);
    else n_pass++;
    n_checks++;
    if (fifo_full !== 3'b000) $display("FAIL reset_full: got %b required 000", fifo_full);
    else n_pass++;
    n_checks++;
    if (data_out !== '0 || hdr_out !== '0 || soft_reset !== '0)
      $display("FAIL reset_out: data=%h hdr=%b sr=%b required 0", data_out, hdr_out, soft_reset);
    else n_pass++;
  endtask

  task automatic test_header_packet();
    wr(1, 1'b1, 8'h15);
    wr(1, 1'b0, 8'hA1);
    wr(1, 1'b0, 8'hA2);
    wr(1, 1'b0, 8'hA3);
    n_checks++;
    if (valid_out[1] !== 1'b1) $display("FAIL pkt_valid: got %b required 1", valid_out[1]);
    else n_pass++;
    for (int k = 0; k < 4; k++) rd_check(1, "pkt_read");
    n_checks++;
    if (valid_out[1] !== 1'b0) $display("FAIL pkt_empty: got %b required 0", valid_out[1]);
    else n_pass++;
    read_enb[1] = 1'b1;
    tick();
    read_enb = '0;
    n_checks++;
    if ({hdr_out[1], data_out[15:8]} !== last_rd[1])
      $display("FAIL empty_read_hold: got %h required %h", {hdr_out[1], data_out[15:8]},
               last_rd[1]);
    else n_pass++;
  endtask

  task automatic test_fill_wrap();
    for (int n = 1; n <= 17; n++) begin
      wr(0, 1'b0, 8'(n));
      if (n == 15) begin
        n_checks++;
        if (fifo_full[0] !== 1'b0) $display("FAIL full_at15: got %b required 0", fifo_full[0]);
        else n_pass++;
      end
      if (n >= 16) begin
        n_checks++;
        if (fifo_full[0] !== 1'b1) $display("FAIL full_at%0d: got %b required 1", n,
                                            fifo_full[0]);
        else n_pass++;
      end
    end
    for (int k = 0; k < 16; k++) rd_check(0, "fill_read");
    n_checks++;
    if (valid_out[0] !== 1'b0) $display("FAIL drop17_empty: got %b required 0", valid_out[0]);
    else n_pass++;
    for (int k = 0; k < 6; k++) wr(0, 1'b0, 8'h60 + 8'(k));
    for (int k = 0; k < 6; k++) rd_check(0, "offset_read");
    for (int k = 0; k < 16; k++) wr(0, k == 0, 8'hC0 + 8'(k));
    n_checks++;
    if (fifo_full[0] !== 1'b1) $display("FAIL wrap_full: got %b required 1", fifo_full[0]);
    else n_pass++;
    for (int k = 0; k < 16; k++) rd_check(0, "wrap_read");
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 16; k++) wr(2, 1'b0, 8'h20 + 8'(k));
    write_enb[2] = 1'b1;
    data_in      = 8'hEE;
    rd_check(2, "full_wr_rd");
    write_enb = '0;
    n_checks++;
    if (fifo_full[2] !== 1'b0) $display("FAIL full_wr_dropped: got %b required 0", fifo_full[2]);
    else n_pass++;
    for (int k = 0; k < 15; k++) rd_check(2, "drain");
    n_checks++;
    if (valid_out[2] !== 1'b0) $display("FAIL drain_empty: got %b required 0", valid_out[2]);
    else n_pass++;
    write_enb[2] = 1'b1;
    read_enb[2]  = 1'b1;
    data_in      = 8'h77;
    sb_push(2, {1'b0, 8'h77});
    tick();
    write_enb = '0;
    read_enb  = '0;
    n_checks++;
    if (valid_out[2] !== 1'b1 || {hdr_out[2], data_out[23:16]} !== last_rd[2])
      $display("FAIL empty_wr_rd: valid=%b data=%h required valid=1 data=%h", valid_out[2],
               {hdr_out[2], data_out[23:16]}, last_rd[2]);
    else n_pass++;
    rd_check(2, "empty_wr_rd_word");
  endtask

  task automatic test_multi_write();
    write_enb = 3'b101;
    data_in   = 8'h42;
    lfd_in    = 1'b1;
    sb_push(0, {1'b1, 8'h42});
    sb_push(2, {1'b1, 8'h42});
    tick();
    write_enb = '0;
    lfd_in    = 1'b0;
    n_checks++;
    if (valid_out !== 3'b101) $display("FAIL multi_valid: got %b required 101", valid_out);
    else n_pass++;
    rd_check(0, "multi_ch0");
    rd_check(2, "multi_ch2");
  endtask

  task automatic test_watchdog();
    int sr_seen;
    wr(0, 1'b0, 8'h99);
    for (int k = 1; k <= 30; k++) begin
      if (k == 10) begin
        write_enb[1] = 1'b1;
        data_in      = 8'h5A;
        sb_push(1, {1'b0, 8'h5A});
      end
      tick();
      write_enb = '0;
      if (k == 29) begin
        n_checks++;
        if (soft_reset !== 3'b000) $display("FAIL wd_early: got %b required 000", soft_reset);
        else n_pass++;
      end
    end
    n_checks++;
    if (soft_reset !== 3'b001 || valid_out[0] !== 1'b1)
      $display("FAIL wd_pulse: sr=%b valid0=%b required sr=001 valid0=1", soft_reset,
               valid_out[0]);
    else n_pass++;
    model_clear(0);
    tick();
    n_checks++;
    if (soft_reset !== 3'b000 || valid_out[0] !== 1'b0 || valid_out[1] !== 1'b1)
      $display("FAIL wd_after: sr=%b valid=%b required sr=000 valid=x10", soft_reset,
               valid_out);
    else n_pass++;
    rd_check(1, "wd_ch1_intact");
    wr(0, 1'b1, 8'h3C);
    sr_seen = 0;
    for (int k = 1; k <= 28; k++) begin
      tick();
      if (soft_reset[0]) sr_seen++;
    end
    rd_check(0, "wd_late_read");
    for (int k = 0; k < 5; k++) begin
      tick();
      if (soft_reset[0]) sr_seen++;
    end
    n_checks++;
    if (sr_seen != 0 || valid_out[0] !== 1'b0)
      $display("FAIL wd_no_flush: pulses=%0d valid0=%b required 0 0", sr_seen, valid_out[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int sr_seen;
    wr(0, 1'b0, 8'h11);
    for (int k = 0; k < 10; k++) tick();
    wr(1, 1'b1, 8'h81);
    wr(1, 1'b0, 8'h82);
    rd_check(1, "pre_reset_read");
    write_enb = 3'b110;
    data_in   = 8'h83;
    resetn    = 1'b1;
    tick();
    write_enb = '0;
    resetn    = 1'b0;
    for (int c = 0; c < NCH; c++) model_clear(c);
    n_checks++;
    if (valid_out !== '0 || fifo_full !== '0 || data_out !== '0 || hdr_out !== '0 ||
        soft_reset !== '0)
      $display("FAIL mid_reset: valid=%b full=%b data=%h hdr=%b sr=%b required all 0",
               valid_out, fifo_full, data_out, hdr_out, soft_reset);
    else n_pass++;
    sr_seen = 0;
    for (int k = 0; k < 35; k++) begin
      tick();
      if (soft_reset !== '0) sr_seen++;
    end
    n_checks++;
    if (sr_seen != 0) $display("FAIL mid_reset_no_sr: pulses=%0d required 0", sr_seen);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_header_packet();
    test_fill_wrap();
    test_simultaneous();
    test_multi_write();
    test_watchdog();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
